dfh_chain_walker: RTL and testbench

DFH_CHAIN_WALKER -- requirements
Module: dfh_chain_walker

---
 rtl/dfh_walker_pkg.sv | 35 +++
 rtl/dfh_chain_walker.sv | 153 +++++++++++++++
 tb/tb_dfh_chain_walker.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dfh_walker_pkg.sv
// Shared types for walking a Device Feature Header chain: the DFH word layout,
// the walker's error causes and its state encoding.
package dfh_walker_pkg;

  localparam int DFH_W     = 64;
  localparam int DFH_OFS_W = 24;

  typedef struct packed {
    logic [3:0]           feature_type;
    logic [18:0]          rsvd;
    logic                 eol;
    logic [DFH_OFS_W-1:0] nxt_dfh_offset;
    logic [3:0]           feature_rev;
    logic [11:0]          feature_id;
  } t_dfh;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_TIMEOUT   = 3'd1,
    ERR_ZERO_OFS  = 3'd2,
    ERR_MISALIGN  = 3'd3,
    ERR_ADDR_OVF  = 3'd4,
    ERR_ENTRY_OVF = 3'd5
  } t_err_code;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_EMIT,
    ST_DONE,
    ST_ERR
  } t_state;

endpackage

// File: rtl/dfh_chain_walker.sv
// Walks a DFH linked list over a simple read port, streaming every header it reads
// and stopping on end-of-list or on the first malformed link.
module dfh_chain_walker
  import dfh_walker_pkg::*;
#(
  parameter  int ADDR_W       = 20,
  parameter  int START_OFFSET = 0,
  parameter  int MAX_ENTRIES  = 32,
  parameter  int RSP_TIMEOUT  = 256,
  localparam int IDX_W        = (MAX_ENTRIES > 1) ? $clog2(MAX_ENTRIES) : 1,
  localparam int CNT_W        = $clog2(RSP_TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_rsp_valid,
  input  logic [DFH_W-1:0]  rd_rsp_data,
  output logic              dfh_valid,
  input  logic              dfh_ready,
  output logic [DFH_W-1:0]  dfh_data,
  output logic [ADDR_W-1:0] dfh_addr,
  output logic [IDX_W-1:0]  dfh_idx,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        err_code
);

  // One spare bit above the wider operand so a carry out of ADDR_W is never lost.
  localparam int SUM_W = ((ADDR_W > DFH_OFS_W) ? ADDR_W : DFH_OFS_W) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_ENTRIES - 1);

  t_state            state_q,    state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [IDX_W-1:0]  idx_q,      idx_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  t_dfh              data_q,     data_d;
  logic              done_q,     done_d;
  logic              error_q,    error_d;
  t_err_code         err_q,      err_d;
  t_err_code         link_err;
  logic [SUM_W-1:0]  next_sum;
  logic              addr_ovf;

  assign next_sum = SUM_W'(cur_addr_q) + SUM_W'(data_q.nxt_dfh_offset);
  assign addr_ovf = (next_sum >> ADDR_W) != '0;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    done_d     = done_q;
    error_d    = error_q;
    err_d      = err_q;
    link_err   = ERR_NONE;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          cur_addr_d = ADDR_W'(START_OFFSET);
          idx_d      = '0;
          cnt_d      = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_d      = ERR_NONE;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (rd_req_ready) begin
          cnt_d   = CNT_W'(1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rd_rsp_valid) begin
          data_d  = t_dfh'(rd_rsp_data);
          state_d = ST_EMIT;
        end else if (cnt_q == CNT_W'(RSP_TIMEOUT)) begin
          error_d = 1'b1;
          err_d   = ERR_TIMEOUT;
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EMIT: begin
        if (dfh_ready) begin
          // Link checks in priority order; the first that trips names the error.
          if (data_q.nxt_dfh_offset == '0)           link_err = ERR_ZERO_OFS;
          else if (data_q.nxt_dfh_offset[2:0] != '0) link_err = ERR_MISALIGN;
          else if (addr_ovf)                         link_err = ERR_ADDR_OVF;
          else if (idx_q == LAST_IDX)                link_err = ERR_ENTRY_OVF;

          if (data_q.eol) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if (link_err != ERR_NONE) begin
            error_d = 1'b1;
            err_d   = link_err;
            state_d = ST_ERR;
          end else begin
            cur_addr_d = next_sum[ADDR_W-1:0];
            idx_d      = idx_q + IDX_W'(1);
            state_d    = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_q      <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_q      <= err_d;
    end
  end

  assign rd_req_valid = (state_q == ST_ISSUE);
  assign rd_req_addr  = cur_addr_q;
  assign dfh_valid    = (state_q == ST_EMIT);
  assign dfh_data     = data_q;
  assign dfh_addr     = cur_addr_q;
  assign dfh_idx      = idx_q;
  assign busy         = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_EMIT);
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_q;

endmodule

// File: tb/tb_dfh_chain_walker.sv
// Self-checking bench: a CSR memory responder drives the walker, and each walk is
// compared against a chain-following reference model built from the DFH rules.
module tb_dfh_chain_walker;
  import dfh_walker_pkg::*;

  localparam int ADDR_W       = 20;
  localparam int START_OFFSET = 0;
  localparam int MAX_ENTRIES  = 4;
  localparam int RSP_TIMEOUT  = 256;
  localparam int IDX_W        = 2;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_rsp_valid;
  logic [63:0]       rd_rsp_data;
  logic              dfh_valid;
  logic              dfh_ready;
  logic [63:0]       dfh_data;
  logic [ADDR_W-1:0] dfh_addr;
  logic [IDX_W-1:0]  dfh_idx;
  logic              busy;
  logic              done;
  logic              error;
  logic [2:0]        err_code;

  dfh_chain_walker #(
    .ADDR_W(ADDR_W), .START_OFFSET(START_OFFSET),
    .MAX_ENTRIES(MAX_ENTRIES), .RSP_TIMEOUT(RSP_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .dfh_valid(dfh_valid), .dfh_ready(dfh_ready), .dfh_data(dfh_data),
    .dfh_addr(dfh_addr), .dfh_idx(dfh_idx),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint      addr;
    logic [63:0] data;
    int          idx;
  } rec_t;

  logic [63:0] mem [longint];
  rec_t        rec_q[$];
  rec_t        exp_q[$];
  int          exp_code;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Environment controls (written by the main sequence only).
  bit hold_rsp     = 1'b0;
  bit drop_rsp     = 1'b0;
  bit force_rdy_lo = 1'b0;

  // Environment state (written by the responder only).
  bit     pend_valid = 1'b0;
  longint pend_addr  = 0;
  int     pend_cnt   = 0;
  int     accepts    = 0;
  int     lat_err    = 0;
  bit     hs_prev    = 1'b0;
  bit     rsp_prev   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_dfh(input bit eol, input logic [23:0] ofs);
    logic [63:0] w;
    w        = {$urandom, $urandom};
    w[40]    = eol;
    w[39:16] = ofs;
    return w;
  endfunction

  // Reference model: follow the chain through mem and list what should be emitted.
  task automatic build_model();
    longint      cur = START_OFFSET;
    int          idx = 0;
    logic [63:0] w;
    longint      ofs;
    exp_q.delete();
    while (1) begin
      w = mem.exists(cur) ? mem[cur] : 64'h0;
      exp_q.push_back('{addr: cur, data: w, idx: idx});
      ofs = longint'(w[39:16]);
      if (w[40] == 1'b1)                            begin exp_code = 0; break; end
      if (ofs == 0)                                 begin exp_code = 2; break; end
      if (ofs % 8 != 0)                             begin exp_code = 3; break; end
      if (cur + ofs > (longint'(1) << ADDR_W) - 1)  begin exp_code = 4; break; end
      if (idx == MAX_ENTRIES - 1)                   begin exp_code = 5; break; end
      cur += ofs;
      idx++;
    end
  endtask

  // CSR memory responder, random backpressure, record capture and latency watch.
  initial begin
    rd_req_ready = 1'b0;
    rd_rsp_valid = 1'b0;
    rd_rsp_data  = '0;
    dfh_ready    = 1'b0;
    forever begin
      @(negedge clk);
      if (hs_prev && busy && !rd_req_valid) lat_err++;
      if (rsp_prev && !dfh_valid)           lat_err++;
      hs_prev  = 1'b0;
      rsp_prev = 1'b0;
      if (drop_rsp) pend_valid = 1'b0;

      rd_rsp_valid = 1'b0;
      rd_rsp_data  = {$urandom, $urandom};
      if (pend_valid && !hold_rsp) begin
        if (pend_cnt > 1) pend_cnt--;
        else begin
          rd_rsp_valid = 1'b1;
          rd_rsp_data  = mem.exists(pend_addr) ? mem[pend_addr] : 64'h0;
          pend_valid   = 1'b0;
          rsp_prev     = busy && !rd_req_valid && !dfh_valid;
        end
      end

      rd_req_ready = ($urandom_range(0, 2) != 0);
      dfh_ready    = force_rdy_lo ? 1'b0 : ($urandom_range(0, 3) != 0);

      if (rd_req_valid && rd_req_ready) begin
        pend_valid = 1'b1;
        pend_addr  = longint'(rd_req_addr);
        pend_cnt   = $urandom_range(1, 4);
        accepts++;
      end
      if (dfh_valid && dfh_ready) begin
        rec_q.push_back('{addr: longint'(dfh_addr), data: dfh_data, idx: int'(dfh_idx)});
        hs_prev = 1'b1;
      end
    end
  end

  task automatic pulse_start(input string tag);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check({tag, "_first_req"},   rd_req_valid, 1);
    check({tag, "_first_addr"},  rd_req_addr,  START_OFFSET);
    check({tag, "_busy"},        busy,         1);
    check({tag, "_done_clr"},    done,         0);
    check({tag, "_err_clr"},     error,        0);
  endtask

  task automatic wait_end(input string tag, input int budget);
    int k = 0;
    while (!(done || error) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ended"}, done || error, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_in_wait(input string tag);
    int k = 0;
    while (!(busy && !rd_req_valid && !dfh_valid) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_in_wait"}, busy && !rd_req_valid && !dfh_valid, 1);
  endtask

  task automatic compare_walk(input string tag);
    check({tag, "_nrec"}, rec_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rec_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), rec_q[i].addr, exp_q[i].addr);
      check($sformatf("%s_data%0d", tag, i), rec_q[i].data, exp_q[i].data);
      check($sformatf("%s_idx%0d",  tag, i), rec_q[i].idx,  exp_q[i].idx);
    end
    check({tag, "_done"},  done,     exp_code == 0);
    check({tag, "_error"}, error,    exp_code != 0);
    check({tag, "_code"},  err_code, exp_code);
    check({tag, "_idle"},  busy,     0);
  endtask

  task automatic run_chain(input string tag);
    build_model();
    rec_q.delete();
    pulse_start(tag);
    wait_end(tag, 3000);
    compare_walk(tag);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint cur;
    int     len;
    int     kind;
    logic [63:0] hold_data;
    logic [ADDR_W-1:0] hold_addr;
    logic [IDX_W-1:0]  hold_idx;
    int     hold_acc;
    int     k;

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_valid", rd_req_valid, 0);
    check("rst_req_addr",  rd_req_addr,  0);
    check("rst_dfh_valid", dfh_valid,    0);
    check("rst_dfh_data",  dfh_data,     0);
    check("rst_dfh_addr",  dfh_addr,     0);
    check("rst_dfh_idx",   dfh_idx,      0);
    check("rst_busy",      busy,         0);
    check("rst_done",      done,         0);
    check("rst_error",     error,        0);
    check("rst_code",      err_code,     0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);

    // Three-entry chain ending on EOL.
    mem.delete();
    mem[64'h0]    = mk_dfh(1'b0, 24'h1000);
    mem[64'h1000] = mk_dfh(1'b0, 24'h2000);
    mem[64'h3000] = mk_dfh(1'b1, 24'h0);
    run_chain("chain3");
    check("chain3_count", rec_q.size(), 3);
    if (rec_q.size() == 3) check("chain3_last_addr", rec_q[2].addr, 64'h3000);

    // Restart from DONE, with a start pulse landing mid-walk that must be ignored.
    build_model();
    rec_q.delete();
    pulse_start("busy_start");
    repeat (4) @(negedge clk);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_end("busy_start", 3000);
    compare_walk("busy_start");

    mem.delete();
    mem[64'h0] = mk_dfh(1'b0, 24'h0);
    run_chain("zero_ofs");
    check("zero_ofs_code2", err_code, 2);

    mem.delete();
    mem[64'h0] = mk_dfh(1'b0, 24'h1004);
    run_chain("misalign");
    check("misalign_code3", err_code, 3);

    mem.delete();
    mem[64'h0]     = mk_dfh(1'b0, 24'h80000);
    mem[64'h80000] = mk_dfh(1'b0, 24'h80000);
    run_chain("addr_ovf");
    check("addr_ovf_code4", err_code, 4);

    mem.delete();
    mem[64'h0] = mk_dfh(1'b0, 24'h200000);
    run_chain("wide_ofs");

    mem.delete();
    for (int i = 0; i < 8; i++) mem[longint'(i) * 64'h1000] = mk_dfh(1'b0, 24'h1000);
    run_chain("entry_ovf");
    check("entry_ovf_count", rec_q.size(), MAX_ENTRIES);
    check("entry_ovf_code5", err_code, 5);

    // Random chains with assorted terminations.
    for (int t = 0; t < 20; t++) begin
      mem.delete();
      cur = START_OFFSET;
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        if (i == len - 1) begin
          kind = $urandom_range(0, 3);
          case (kind)
            0:       mem[cur] = mk_dfh(1'b1, 24'($urandom));
            1:       mem[cur] = mk_dfh(1'b0, 24'h0);
            2:       mem[cur] = mk_dfh(1'b0, 24'($urandom_range(1, 'h3FFF) * 8 + 4));
            default: mem[cur] = mk_dfh(1'b0, 24'hFFFFF8);
          endcase
        end else begin
          mem[cur] = mk_dfh(1'b0, 24'($urandom_range(1, 'h3FFF) * 8));
          cur += longint'(mem[cur][39:16]);
        end
      end
      run_chain($sformatf("rnd%0d", t));
    end

    // Response withheld: timeout with no record emitted.
    hold_rsp = 1'b1;
    rec_q.delete();
    pulse_start("tmo");
    wait_in_wait("tmo");
    repeat (250) @(negedge clk);
    check("tmo_still_busy", busy,  1);
    check("tmo_not_yet",    error, 0);
    k = 0;
    while (!error && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("tmo_error", error,        1);
    check("tmo_code1", err_code,     1);
    check("tmo_busy",  busy,         0);
    check("tmo_done",  done,         0);
    check("tmo_nrec",  rec_q.size(), 0);
    @(posedge clk); #1 drop_rsp = 1'b1; hold_rsp = 1'b0;
    @(posedge clk); #1 drop_rsp = 1'b0;

    // Consumer stalls for 10 cycles: record held, no new read.
    mem.delete();
    mem[64'h0]    = mk_dfh(1'b0, 24'h1000);
    mem[64'h1000] = mk_dfh(1'b1, 24'h0);
    build_model();
    rec_q.delete();
    force_rdy_lo = 1'b1;
    pulse_start("stall");
    k = 0;
    while (!dfh_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("stall_valid_seen", dfh_valid, 1);
    hold_data = dfh_data;
    hold_addr = dfh_addr;
    hold_idx  = dfh_idx;
    hold_acc  = accepts;
    repeat (10) begin
      @(negedge clk);
      check("stall_valid", dfh_valid,    1);
      check("stall_data",  dfh_data,     hold_data);
      check("stall_addr",  dfh_addr,     hold_addr);
      check("stall_idx",   dfh_idx,      hold_idx);
      check("stall_noreq", rd_req_valid, 0);
    end
    check("stall_no_accept", accepts, hold_acc);
    @(posedge clk); #1 force_rdy_lo = 1'b0;
    wait_end("stall", 3000);
    compare_walk("stall");

    // Reset while waiting for a response; the late response must be ignored.
    mem.delete();
    mem[64'h0]    = mk_dfh(1'b0, 24'h1000);
    mem[64'h1000] = mk_dfh(1'b0, 24'h1000);
    mem[64'h2000] = mk_dfh(1'b1, 24'h0);
    hold_rsp = 1'b1;
    rec_q.delete();
    pulse_start("mid_rst");
    wait_in_wait("mid_rst");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",      busy,         0);
    check("mid_rst_req_valid", rd_req_valid, 0);
    check("mid_rst_req_addr",  rd_req_addr,  0);
    check("mid_rst_dfh_valid", dfh_valid,    0);
    check("mid_rst_dfh_data",  dfh_data,     0);
    check("mid_rst_dfh_idx",   dfh_idx,      0);
    check("mid_rst_code",      err_code,     0);
    @(posedge clk); #1 rst_n = 1'b1; hold_rsp = 1'b0;
    repeat (8) @(negedge clk);
    check("stale_consumed", pend_valid,   0);
    check("stale_busy",     busy,         0);
    check("stale_dfh",      dfh_valid,    0);
    check("stale_nrec",     rec_q.size(), 0);
    run_chain("post_rst");

    check("latency_violations", lat_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
